// File: rtl/tick_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tick_arb_pkg                                                |
// | Purpose  : Shared definitions for the tick arbiter: FSM state encoding |
// |            and default sizing of the requester set and the counter.    |
// | Ports    : none (package)                                              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package tick_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_CNT_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/tick_arbiter_rr_picker.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : rr_picker                                                   |
// | Purpose  : Combinational round-robin selector. Returns the first set   |
// |            request bit found searching upward from the pointer,        |
// |            wrapping modulo NUM_REQ.                                    |
// | Ports    : req     [NUM_REQ-1:0] in  - request vector                  |
// |            pointer [IDX_W-1:0]   in  - highest-priority index          |
// |            valid                 out - at least one request is set     |
// |            winner  [IDX_W-1:0]   out - selected index (0 if !valid)    |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module rr_picker
  import tick_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] idx;

  // Walk NUM_REQ positions starting at the pointer; the first hit wins.
  // The explicit wrap at LAST_IDX keeps non-power-of-two sizes correct.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = pointer;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
      idx = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/tick_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tick_arbiter                                                |
// | Purpose  : Shares one countdown timer among NUM_REQ requesters. Grants |
// |            round-robin, latches the winner's period, counts it down    |
// |            and pulses the winner's done for one cycle.                 |
// | Ports    : clk, reset (sync, active high)                              |
// |            abort      in  - only with TICK_ARB_ABORT_EN: cancel count  |
// |            req        in  [NUM_REQ]       level requests               |
// |            period     in  [NUM_REQ*CNT_W] flattened periods            |
// |            grant      out [NUM_REQ]       one-hot timer owner          |
// |            done       out [NUM_REQ]       one-cycle completion pulse   |
// |            busy       out                 not idle                     |
// |            remaining  out [CNT_W]         current countdown value      |
// | Options  : `define TICK_ARB_ABORT_EN adds the abort input.             |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tick_arbiter
  import tick_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef TICK_ARB_ABORT_EN
  input  logic                     abort,
`endif
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] period,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [CNT_W-1:0]         remaining
);

  localparam int               IDX_W    = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     remaining_q, remaining_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [CNT_W-1:0]     period_arr [NUM_REQ];
  logic [CNT_W-1:0]     sel_period;
  logic [IDX_W-1:0]     ptr_after;
  logic                 abort_req;

`ifdef TICK_ARB_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack_period
    assign period_arr[i] = period[i*CNT_W +: CNT_W];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (req),
    .pointer (ptr_q),
    .valid   (pick_valid),
    .winner  (pick_idx)
  );

  assign sel_period = period_arr[pick_idx];
  // Priority moves to the requester just after the one that owned the timer.
  assign ptr_after  = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    done_d      = '0;
    busy_d      = busy_q;
    remaining_d = remaining_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d     = ST_COUNT;
          owner_d     = pick_idx;
          grant_d     = NUM_REQ'(1) << pick_idx;
          busy_d      = 1'b1;
          // Load P-1 so that done lands exactly P cycles after grant;
          // a zero period is treated as one.
          remaining_d = (sel_period == '0) ? '0 : sel_period - CNT_W'(1);
        end
      end
      ST_COUNT: begin
        if (abort_req) begin
          state_d     = ST_IDLE;
          grant_d     = '0;
          busy_d      = 1'b0;
          remaining_d = '0;
          ptr_d       = ptr_after;
        end else if (remaining_q == '0) begin
          state_d = ST_DONE;
          done_d  = grant_q;
        end else begin
          remaining_d = remaining_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        ptr_d   = ptr_after;
      end
      default: begin
        state_d     = ST_IDLE;
        grant_d     = '0;
        busy_d      = 1'b0;
        remaining_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      remaining_q <= '0;
      ptr_q       <= '0;
      owner_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      remaining_q <= remaining_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign remaining = remaining_q;

endmodule
`default_nettype wire

// File: tb/tb_tick_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_tick_arbiter                                             |
// | Purpose  : Self-checking bench for tick_arbiter. A timestamp-based     |
// |            reference model (owner, period, age since grant) predicts   |
// |            every output each cycle; scenario tasks add directed checks.|
// | Ports    : none                                                        |
// | Options  : TICK_ARB_ABORT_EN enables the abort scenario.               |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_tick_arbiter;

  localparam int NR = 4;
  localparam int CW = 8;
  localparam int OW = 2*NR + 1 + CW;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              abort = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*CW-1:0]  period = '0;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     done;
  logic              busy;
  logic [CW-1:0]     remaining;

  wire  [OW-1:0]     dut_out = {grant, done, busy, remaining};

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: who owns the timer, its effective period, and how
  // many cycles have elapsed since its grant became visible.
  bit m_busy = 1'b0;
  int m_owner = 0;
  int m_p = 0;
  int m_age = 0;
  int m_ptr = 0;

  tick_arbiter #(.NUM_REQ(NR), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef TICK_ARB_ABORT_EN
    .abort     (abort),
`endif
    .req       (req),
    .period    (period),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit found;
    int c;
    int p;
    if (reset) begin
      m_busy = 1'b0;
      m_ptr  = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < NR; k++) begin
        c = (m_ptr + k) % NR;
        if (!found && req[c]) begin
          found   = 1'b1;
          p       = int'(period[c*CW +: CW]);
          m_busy  = 1'b1;
          m_owner = c;
          m_age   = 0;
          m_p     = (p == 0) ? 1 : p;
        end
      end
    end else if (abort && m_age < m_p) begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % NR;
    end else begin
      m_age++;
      if (m_age > m_p) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % NR;
      end
    end
  endtask

  function automatic logic [OW-1:0] exp_out();
    logic [NR-1:0] g;
    logic [NR-1:0] d;
    logic [CW-1:0] r;
    if (!m_busy) return '0;
    g = '0;
    g[m_owner] = 1'b1;
    d = (m_age == m_p) ? g : '0;
    r = (m_age < m_p) ? CW'(m_p - 1 - m_age) : '0;
    return {g, d, 1'b1, r};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = '1;
    period = '1;
    cycle();
    cycle();
    n_checks++;
    if (dut_out !== '0) begin
      n_errors++;
      $display("FAIL reset_state cyc=%0d got=%h exp=0", cyc, dut_out);
    end
    reset = 1'b0;
    req = '0;
    period = '0;
    cycle();
    n_checks++;
    if (dut_out !== exp_out()) begin
      n_errors++;
      $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, dut_out, exp_out());
    end
  endtask

  task automatic test_single();
    int g = -1;
    int d = -1;
    req = 4'b0001;
    period[0 +: CW] = 8'd5;
    for (int i = 0; i < 9; i++) begin
      cycle();
      if (grant != '0) req = '0;
      if (g < 0 && grant == 4'b0001) g = cyc;
      if (d < 0 && done == 4'b0001) d = cyc;
      n_checks++;
      if (dut_out !== exp_out()) begin
        n_errors++;
        $display("FAIL single cyc=%0d got=%h exp=%h", cyc, dut_out, exp_out());
      end
    end
    n_checks++;
    if (g < 0 || d - g != 5) begin
      n_errors++;
      $display("FAIL single_latency got=%0d exp=5", d - g);
    end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] seq [$];
    logic [NR-1:0] prev = '0;
    logic [NR-1:0] want [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req = '1;
    for (int i = 0; i < NR; i++) period[i*CW +: CW] = 8'd2;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (grant != '0 && prev == '0) seq.push_back(grant);
      prev = grant;
      n_checks++;
      if (dut_out !== exp_out()) begin
        n_errors++;
        $display("FAIL round_robin cyc=%0d got=%h exp=%h", cyc, dut_out, exp_out());
      end
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= seq.size() || seq[i] !== want[i]) begin
        n_errors++;
        $display("FAIL rr_order idx=%0d got=%b exp=%b", i,
                 (i < seq.size()) ? seq[i] : 4'bx, want[i]);
      end
    end
    req = '0;
    cycle();
    cycle();
  endtask

  task automatic test_zero_period();
    int g = -1;
    int d = -1;
    req = 4'b0100;
    period[2*CW +: CW] = 8'd0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (g < 0 && grant == 4'b0100) begin
        g = cyc;
        period[2*CW +: CW] = 8'd9;
        req = '0;
      end
      if (d < 0 && done == 4'b0100) d = cyc;
      n_checks++;
      if (dut_out !== exp_out()) begin
        n_errors++;
        $display("FAIL zero_period cyc=%0d got=%h exp=%h", cyc, dut_out, exp_out());
      end
    end
    n_checks++;
    if (g < 0 || d - g != 1) begin
      n_errors++;
      $display("FAIL zero_latency got=%0d exp=1", d - g);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_done = 1'b0;
    int g = -1;
    req = 4'b0010;
    period[1*CW +: CW] = 8'd100;
    for (int i = 0; i < 6 && g < 0; i++) begin
      cycle();
      if (grant == 4'b0010) g = cyc;
    end
    n_checks++;
    if (g < 0) begin
      n_errors++;
      $display("FAIL reset_mid_grant got=%b exp=0010", grant);
    end
    req = '0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (done != '0) saw_done = 1'b1;
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_checks++;
    if (dut_out !== '0 || saw_done) begin
      n_errors++;
      $display("FAIL reset_mid got=%h done_seen=%0d exp=0", dut_out, saw_done);
    end
    req = '1;
    cycle();
    n_checks++;
    if (grant !== 4'b0001) begin
      n_errors++;
      $display("FAIL reset_mid_ptr got=%b exp=0001", grant);
    end
    req = '0;
    for (int i = 0; i < 6; i++) cycle();
  endtask

  task automatic test_withdraw_wrap();
    logic [NR-1:0] next_g = '0;
    bit was_idle = 1'b0;
    do_reset();
    req = 4'b1000;
    period[3*CW +: CW] = 8'd3;
    period[0 +: CW] = 8'd1;
    period[2*CW +: CW] = 8'd1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (grant == 4'b1000) req = 4'b0101;
      if (grant == '0 && req == 4'b0101) was_idle = 1'b1;
      if (was_idle && next_g == '0 && grant != '0) next_g = grant;
      n_checks++;
      if (dut_out !== exp_out()) begin
        n_errors++;
        $display("FAIL withdraw cyc=%0d got=%h exp=%h", cyc, dut_out, exp_out());
      end
    end
    n_checks++;
    if (next_g !== 4'b0001) begin
      n_errors++;
      $display("FAIL wrap_next got=%b exp=0001", next_g);
    end
    req = '0;
    for (int i = 0; i < 4; i++) cycle();
  endtask

  task automatic test_max_period();
    int g = -1;
    int d = -1;
    req = 4'b0010;
    period[1*CW +: CW] = 8'd255;
    for (int i = 0; i < 270 && d < 0; i++) begin
      cycle();
      if (g < 0 && grant == 4'b0010) begin
        g = cyc;
        req = '0;
      end
      if (d < 0 && done == 4'b0010) d = cyc;
      n_checks++;
      if (dut_out !== exp_out()) begin
        n_errors++;
        $display("FAIL max_period cyc=%0d got=%h exp=%h", cyc, dut_out, exp_out());
      end
    end
    n_checks++;
    if (g < 0 || d - g != 255) begin
      n_errors++;
      $display("FAIL max_latency got=%0d exp=255", d - g);
    end
    cycle();
  endtask

`ifdef TICK_ARB_ABORT_EN
  task automatic test_abort();
    bit saw_done = 1'b0;
    do_reset();
    req = 4'b0101;
    period[0 +: CW] = 8'd50;
    period[2*CW +: CW] = 8'd3;
    cycle();
    n_checks++;
    if (grant !== 4'b0001) begin
      n_errors++;
      $display("FAIL abort_grant got=%b exp=0001", grant);
    end
    req = 4'b0100;
    for (int i = 0; i < 10; i++) cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    n_checks++;
    if (dut_out !== '0) begin
      n_errors++;
      $display("FAIL abort_idle got=%h exp=0", dut_out);
    end
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (done == 4'b0001) saw_done = 1'b1;
      n_checks++;
      if (dut_out !== exp_out()) begin
        n_errors++;
        $display("FAIL abort_next cyc=%0d got=%h exp=%h", cyc, dut_out, exp_out());
      end
    end
    n_checks++;
    if (saw_done) begin
      n_errors++;
      $display("FAIL abort_done got=1 exp=0");
    end
    req = '0;
    for (int i = 0; i < 4; i++) cycle();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      req = NR'($urandom);
      for (int k = 0; k < NR; k++) period[k*CW +: CW] = CW'($urandom_range(0, 6));
      reset = ($urandom_range(0, 59) == 0);
`ifdef TICK_ARB_ABORT_EN
      abort = ($urandom_range(0, 7) == 0);
`endif
      cycle();
      n_checks++;
      if (dut_out !== exp_out()) begin
        n_errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_out, exp_out());
      end
    end
    reset = 1'b0;
    abort = 1'b0;
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_period();
    test_reset_mid();
    test_withdraw_wrap();
    test_max_period();
`ifdef TICK_ARB_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
